// File: rtl/dot3_issue_ctrl.sv
// Issue controller in front of the 3-element float32 dot-product unit.
// Buffers operand vectors in a 2-entry FIFO, drives one vector at a time to
// the dot unit, holds it for LATENCY cycles, then captures and presents the
// result over a valid/ready handshake. Values pass through bit-exact.

module dot3_issue_ctrl #(
  parameter int unsigned LATENCY = 32,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  // Upstream operand handshake
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a0,
  input  logic [31:0] in_a1,
  input  logic [31:0] in_a2,
  input  logic [31:0] in_b0,
  input  logic [31:0] in_b1,
  input  logic [31:0] in_b2,
  // Operands to the dot unit
  output logic [31:0] dot_a0,
  output logic [31:0] dot_a1,
  output logic [31:0] dot_a2,
  output logic [31:0] dot_b0,
  output logic [31:0] dot_b1,
  output logic [31:0] dot_b2,
  input  logic [31:0] dot_out,
  // Downstream result handshake
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LATENCY - 1);

  logic [1:0]       r_state;
  logic [191:0]     r_q_mem [2];
  logic [1:0]       r_q_cnt;
  logic             r_q_rd;
  logic             r_q_wr;
  logic [CNT_W-1:0] r_cnt;
  logic [191:0]     r_dot_vec;
  logic [31:0]      r_out_result;
  logic             r_out_valid;

  logic             w_push;
  logic             w_pop;
  logic             w_out_hs;
  logic             w_lat_hit;
  logic [191:0]     w_in_vec;
  logic [191:0]     w_head;

  // in_ready depends only on registered count; a same-cycle pop does not raise it.
  assign in_ready  = (r_q_cnt != 2'd2);
  assign w_push    = in_valid & in_ready;
  assign w_out_hs  = r_out_valid & out_ready;
  assign w_lat_hit = (r_cnt == LastCnt);
  assign w_in_vec  = {in_a0, in_a1, in_a2, in_b0, in_b1, in_b2};
  assign w_head    = r_q_mem[r_q_rd];

  // Pop the head when idle, or back-to-back when the current result is taken.
  always_comb begin
    w_pop = 1'b0;
    if (r_q_cnt != 2'd0) begin
      if (r_state == S_IDLE) begin
        w_pop = 1'b1;
      end else if ((r_state == S_DONE) && w_out_hs) begin
        w_pop = 1'b1;
      end
    end
  end

  // Operand FIFO: storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_cnt <= 2'd0;
      r_q_rd  <= 1'b0;
      r_q_wr  <= 1'b0;
    end else begin
      if (w_push) begin
        r_q_mem[r_q_wr] <= w_in_vec;
        r_q_wr          <= ~r_q_wr;
      end
      if (w_pop) begin
        r_q_rd <= ~r_q_rd;
      end
      case ({w_push, w_pop})
        2'b10:   r_q_cnt <= r_q_cnt + 2'd1;
        2'b01:   r_q_cnt <= r_q_cnt - 2'd1;
        default: r_q_cnt <= r_q_cnt;
      endcase
    end
  end

  // Issue FSM: load operands, wait out the unit latency, capture and hand off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_dot_vec    <= '0;
      r_out_result <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_dot_vec <= w_head;
            r_cnt     <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_lat_hit) begin
            r_out_result <= dot_out;
            r_out_valid  <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            if (w_pop) begin
              r_dot_vec <= w_head;
              r_cnt     <= '0;
              r_state   <= S_RUN;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dot_a0     = r_dot_vec[191:160];
  assign dot_a1     = r_dot_vec[159:128];
  assign dot_a2     = r_dot_vec[127:96];
  assign dot_b0     = r_dot_vec[95:64];
  assign dot_b1     = r_dot_vec[63:32];
  assign dot_b2     = r_dot_vec[31:0];
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign busy       = (r_state != S_IDLE) || (r_q_cnt != 2'd0);

endmodule

// File: tb/tb_dot3_issue_ctrl.sv
// Directed bench for dot3_issue_ctrl: a LATENCY=32 instance with a lookup-table
// dot unit and result scoreboard, plus a LATENCY=1 instance.

module tb_dot3_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Known vectors {a0,a1,a2,b0,b1,b2} and their float32 dot products.
  localparam logic [191:0] VEC [9] = '{
    {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000},
    {32'h3F800000, 32'h00000000, 32'h00000000, 32'hC0000000, 32'h00000000, 32'h00000000},
    {32'h40000000, 32'h00000000, 32'h00000000, 32'h40400000, 32'h00000000, 32'h00000000},
    {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000},
    {32'h3F000000, 32'h00000000, 32'h00000000, 32'h40000000, 32'h00000000, 32'h00000000},
    {32'h40800000, 32'h00000000, 32'h00000000, 32'h40800000, 32'h00000000, 32'h00000000},
    {32'h3F800000, 32'h3F800000, 32'h00000000, 32'h40000000, 32'h40000000, 32'h00000000},
    {32'h7FC00000, 32'h00000000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000},
    {32'h7F800000, 32'h00000000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000}
  };
  localparam logic [31:0] RES [9] = '{
    32'h42000000, 32'hC0000000, 32'h40C00000, 32'h40400000, 32'h3F800000,
    32'h41800000, 32'h40800000, 32'h7FC00000, 32'h7F800000
  };

  function automatic logic [31:0] dotf(input logic [191:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      if (v == VEC[i]) r = RES[i];
    end
    return r;
  endfunction

  // Instance A (LATENCY=32)
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_a0, in_a1, in_a2, in_b0, in_b1, in_b2;
  logic [31:0] dot_a0, dot_a1, dot_a2, dot_b0, dot_b1, dot_b2, dot_out, out_result;

  assign dot_out = dotf({dot_a0, dot_a1, dot_a2, dot_b0, dot_b1, dot_b2});

  dot3_issue_ctrl #(.LATENCY(32), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_a2(in_a2),
    .in_b0(in_b0), .in_b1(in_b1), .in_b2(in_b2),
    .dot_a0(dot_a0), .dot_a1(dot_a1), .dot_a2(dot_a2),
    .dot_b0(dot_b0), .dot_b1(dot_b1), .dot_b2(dot_b2),
    .dot_out(dot_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy)
  );

  // Instance B (LATENCY=1)
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [31:0] b_in_a0, b_in_a1, b_in_a2, b_in_b0, b_in_b1, b_in_b2;
  logic [31:0] b_dot_a0, b_dot_a1, b_dot_a2, b_dot_b0, b_dot_b1, b_dot_b2;
  logic [31:0] b_dot_out, b_out_result;

  assign b_dot_out = dotf({b_dot_a0, b_dot_a1, b_dot_a2, b_dot_b0, b_dot_b1, b_dot_b2});

  dot3_issue_ctrl #(.LATENCY(1), .CNT_W(2)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a0(b_in_a0), .in_a1(b_in_a1), .in_a2(b_in_a2),
    .in_b0(b_in_b0), .in_b1(b_in_b1), .in_b2(b_in_b2),
    .dot_a0(b_dot_a0), .dot_a1(b_dot_a1), .dot_a2(b_dot_a2),
    .dot_b0(b_dot_b0), .dot_b1(b_dot_b1), .dot_b2(b_dot_b2),
    .dot_out(b_dot_out),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
    .busy(b_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [191:0] pend_q [$];
  logic [31:0]  exp_q [$];
  int           xfer_cyc [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present the head of the offer list on instance A's input port.
  task automatic drive();
    if (pend_q.size() > 0) begin
      in_valid = 1'b1;
      {in_a0, in_a1, in_a2, in_b0, in_b1, in_b2} = pend_q[0];
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic offer(input logic [191:0] v);
    pend_q.push_back(v);
    drive();
  endtask

  // One clock: record handshakes completed at this edge and score results in order.
  task automatic tick();
    logic        in_hs, out_hs;
    logic [31:0] res_seen;
    in_hs    = in_valid && in_ready && !rst;
    out_hs   = out_valid && out_ready && !rst;
    res_seen = out_result;
    @(posedge clk);
    #1;
    cyc++;
    if (in_hs) begin
      acc_cyc = cyc;
      exp_q.push_back(dotf(pend_q[0]));
      void'(pend_q.pop_front());
    end
    if (out_hs) begin
      xfer_cyc.push_back(cyc);
      check("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("result_order", res_seen, exp_q.pop_front());
    end
    drive();
  endtask

  task automatic wait_out_valid(input string tag, input int bound);
    int n;
    n = 0;
    while (!out_valid && n < bound) begin
      tick();
      n++;
    end
    if (!out_valid) check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stable;
    int   n, n0, sz;

    rst = 1'b1;
    in_valid = 1'b0;
    {in_a0, in_a1, in_a2, in_b0, in_b1, in_b2} = '0;
    out_ready = 1'b0;
    b_in_valid = 1'b0;
    {b_in_a0, b_in_a1, b_in_a2, b_in_b0, b_in_b1, b_in_b2} = '0;
    b_out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_dot_a0", dot_a0, 32'h0);
    check("rst_dot_b2", dot_b2, 32'h0);
    check("rst_out_result", out_result, 32'h0);

    // Single vector, out_ready high: latency and operand stability
    out_ready = 1'b1;
    offer(VEC[0]);
    tick();
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_dot_a0", dot_a0, 32'h3F800000);
    check("t1_dot_b2", dot_b2, 32'h40C00000);
    stable = 1'b1;
    n = 0;
    while (!out_valid && n < 60) begin
      if ({dot_a0, dot_a1, dot_a2, dot_b0, dot_b1, dot_b2} !== VEC[0]) stable = 1'b0;
      tick();
      n++;
    end
    check("t1_dot_stable", 32'(stable), 32'd1);
    check("t1_latency", 32'(cyc - acc_cyc), 32'd33);
    check("t1_result", out_result, 32'h42000000);
    tick();
    check("t1_valid_drop", 32'(out_valid), 32'd0);
    check("t1_busy_drop", 32'(busy), 32'd0);

    // Backpressure: one vector parked in DONE, two queued, third held upstream
    out_ready = 1'b0;
    offer(VEC[2]);
    wait_out_valid("t2_first_timeout", 60);
    offer(VEC[3]);
    offer(VEC[4]);
    offer(VEC[5]);
    tick();
    check("t2_ready_after_1", 32'(in_ready), 32'd1);
    tick();
    check("t2_ready_after_2", 32'(in_ready), 32'd0);
    repeat (3) tick();
    check("t2_ready_held", 32'(in_ready), 32'd0);
    check("t2_third_held", 32'(pend_q.size()), 32'd1);
    check("t2_dot_hold", dot_a0, 32'h40000000);

    // Stall in DONE for 10 cycles, then a single-cycle out_ready
    repeat (10) tick();
    check("t3_valid_stall", 32'(out_valid), 32'd1);
    check("t3_result_stall", out_result, 32'h40C00000);
    n0 = xfer_cyc.size();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_valid_after_one", 32'(out_valid), 32'd0);
    check("t3_next_loaded", dot_a0, 32'h3F800000);
    repeat (3) tick();
    check("t3_one_xfer", 32'(xfer_cyc.size() - n0), 32'd1);
    check("t3_third_taken", 32'(pend_q.size()), 32'd0);

    // Drain: back-to-back RUN, one result per LATENCY+1 cycles
    wait_out_valid("t2_second_timeout", 60);
    out_ready = 1'b1;
    drain("t2_drain", 300);
    sz = xfer_cyc.size();
    check("t2_interval_a", 32'(xfer_cyc[sz - 1] - xfer_cyc[sz - 2]), 32'd33);
    check("t2_interval_b", 32'(xfer_cyc[sz - 2] - xfer_cyc[sz - 3]), 32'd33);
    tick();
    check("t2_idle", 32'(busy), 32'd0);

    // Simultaneous push and pop with one entry queued
    out_ready = 1'b0;
    offer(VEC[6]);
    wait_out_valid("t4_first_timeout", 60);
    offer(VEC[7]);
    tick();
    check("t4_ready_cnt1", 32'(in_ready), 32'd1);
    offer(VEC[8]);
    out_ready = 1'b1;
    tick();
    check("t4_ready_still", 32'(in_ready), 32'd1);
    check("t4_nan_loaded", dot_a0, 32'h7FC00000);
    check("t4_pushed", 32'(pend_q.size()), 32'd0);
    drain("t4_drain", 300);

    // Reset mid-RUN with one vector queued
    out_ready = 1'b1;
    offer(VEC[0]);
    offer(VEC[2]);
    repeat (7) tick();
    check("t5_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_dot_a0", dot_a0, 32'h0);
    rst = 1'b0;
    exp_q.delete();
    n0 = xfer_cyc.size();
    repeat (80) tick();
    check("t5_no_result", 32'(xfer_cyc.size() - n0), 32'd0);
    check("t5_still_idle", 32'(busy), 32'd0);

    // LATENCY=1 instance
    b_in_valid = 1'b1;
    {b_in_a0, b_in_a1, b_in_a2, b_in_b0, b_in_b1, b_in_b2} = VEC[1];
    check("t6_ready", 32'(b_in_ready), 32'd1);
    tick();
    b_in_valid = 1'b0;
    check("t6_valid_t0", 32'(b_out_valid), 32'd0);
    tick();
    check("t6_valid_t1", 32'(b_out_valid), 32'd0);
    check("t6_dot_b0", b_dot_b0, 32'hC0000000);
    tick();
    check("t6_valid_t2", 32'(b_out_valid), 32'd1);
    check("t6_result", b_out_result, 32'hC0000000);
    tick();
    check("t6_valid_drop", 32'(b_out_valid), 32'd0);
    check("t6_busy", 32'(b_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
